mbs_arbitro: RTL and testbench

MBS_ARBITRO -- requirements
Module: mbs_arbitro

---
 rtl/mbs_pkg.sv | 13 +
 rtl/mbs_nucleo.sv | 55 +++++
 rtl/mbs_arbitro.sv | 109 ++++++++++
 tb/tb_mbs_arbitro.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbs_pkg.sv
// Shared definitions for the mbs_arbitro shift-add multiplier:
// FSM state encoding and the default operand width.
package mbs_pkg;

  localparam int LARGURA_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CALCULA  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

endpackage

// File: rtl/mbs_nucleo.sv
// Shift-add multiplier datapath: operand/accumulator registers, iteration counter
// and end-of-calculation detect. MBS_ARBITRO_EARLY_EXIT_EN enables early exit when a runs out of ones.
module mbs_nucleo
  import mbs_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   carga,
  input  logic                   passo,
  input  logic [LARGURA-1:0]     a_in,
  input  logic [LARGURA-1:0]     b_in,
  output logic [2*LARGURA-1:0]   produto,
  output logic                   ultimo
);

  localparam int CW = $clog2(LARGURA + 1);

  logic [LARGURA-1:0]   a_q;
  logic [2*LARGURA-1:0] b_q;
  logic [2*LARGURA-1:0] acc_q;
  logic [CW-1:0]        cnt_q;

  // NOTE: non-blocking assignments keep every register reading the pre-edge
  // values of the others, so acc sees the old b and a in the same step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (carga) begin
      a_q   <= a_in;
      b_q   <= {{LARGURA{1'b0}}, b_in};
      acc_q <= '0;
      cnt_q <= '0;
    end else if (passo) begin
      if (a_q[0]) acc_q <= acc_q + b_q;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign produto = acc_q;

  // ultimo flags that the step being taken on this edge is the final one.
`ifdef MBS_ARBITRO_EARLY_EXIT_EN
  assign ultimo = (cnt_q == CW'(LARGURA - 1)) || ((a_q >> 1) == '0);
`else
  assign ultimo = (cnt_q == CW'(LARGURA - 1));
`endif

endmodule

// File: rtl/mbs_arbitro.sv
// Two-requester arbiter in front of a sequential shift-add multiplier with a
// valid/ready response port. MBS_ARBITRO_EARLY_EXIT_EN shortens latency (see mbs_nucleo).
module mbs_arbitro
  import mbs_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [LARGURA-1:0]   req0_a,
  input  logic [LARGURA-1:0]   req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [LARGURA-1:0]   req1_a,
  input  logic [LARGURA-1:0]   req1_b,
  output logic                 req1_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*LARGURA-1:0] resp_produto,
  output logic                 busy
);

  estado_t              estado;
  logic                 prio;
  logic                 id_q;
  logic                 aceita0;
  logic                 aceita1;
  logic                 carga;
  logic                 passo;
  logic                 ultimo;
  logic [LARGURA-1:0]   a_sel;
  logic [LARGURA-1:0]   b_sel;

  // NOTE: every signal gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (estado == OCIOSO) begin
      req0_ready = req0_valid && (!req1_valid || !prio);
      req1_ready = req1_valid && (!req0_valid ||  prio);
    end
  end

  assign aceita0 = req0_valid && req0_ready;
  assign aceita1 = req1_valid && req1_ready;
  assign carga   = aceita0 || aceita1;
  assign passo   = (estado == CALCULA);
  assign a_sel   = aceita1 ? req1_a : req0_a;
  assign b_sel   = aceita1 ? req1_b : req0_b;

  mbs_nucleo #(
    .LARGURA (LARGURA)
  ) u_nucleo (
    .clock   (clock),
    .reset   (reset),
    .carga   (carga),
    .passo   (passo),
    .a_in    (a_sel),
    .b_in    (b_sel),
    .produto (resp_produto),
    .ultimo  (ultimo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      prio       <= 1'b0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (carga) begin
            id_q   <= aceita1;
            busy   <= 1'b1;
            estado <= CALCULA;
          end
        end
        CALCULA: begin
          if (ultimo) begin
            resp_valid <= 1'b1;
            estado     <= RESPOSTA;
          end
        end
        RESPOSTA: begin
          // Fairness: the other requester wins the next tie.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            prio       <= ~id_q;
            estado     <= OCIOSO;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          estado     <= OCIOSO;
        end
      endcase
    end
  end

  assign resp_id = id_q;

endmodule

// File: tb/tb_mbs_arbitro.sv
// Self-checking bench for mbs_arbitro: scoreboard of expected responses,
// one task per scenario; latency expectation follows MBS_ARBITRO_EARLY_EXIT_EN.
module tb_mbs_arbitro;

  localparam int L = 8;

  logic           clock;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic [L-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           resp_valid, resp_ready, resp_id;
  logic [2*L-1:0] resp_produto;
  logic           busy;

  typedef struct {
    logic           id;
    logic [2*L-1:0] produto;
  } esperado_t;

  esperado_t sb[$];
  int total = 0;
  int bad   = 0;

  mbs_arbitro #(.LARGURA(L)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_produto (resp_produto),
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [2*L-1:0] modelo(input logic [L-1:0] a, input logic [L-1:0] b);
    return (2*L)'(a) * (2*L)'(b);
  endfunction

  function automatic int lat_esperada(input logic [L-1:0] a);
    int n;
    n = L;
`ifdef MBS_ARBITRO_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < L; i++) if (a[i]) n = i + 1;
`endif
    return n;
  endfunction

  task automatic do_reset;
    reset      = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  // Counts edges after the acceptance edge until resp_valid is seen; -1 on timeout.
  task automatic esperar_resp(input int limite, output int lat);
    lat = -1;
    for (int i = 1; i <= limite; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({resp_valid, busy, resp_id, resp_produto, req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b busy=%b id=%b prod=%h rdy=%b%b want all 0",
               resp_valid, busy, resp_id, resp_produto, req0_ready, req1_ready);
    end
    do_reset;
  endtask

  task automatic test_req0_only;
    int lat;
    esperado_t e;
    do_reset;
    req0_valid = 1'b1; req0_a = 8'd13; req0_b = 8'd11; resp_ready = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL t1_grant: got rdy0/1=%b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clock);
    sb.push_back('{id: 1'b0, produto: modelo(8'd13, 8'd11)});
    #1;
    req0_valid = 1'b0;
    total++;
    if (req0_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_after_accept: got rdy0=%b busy=%b want 0 1", req0_ready, busy);
    end
    esperar_resp(30, lat);
    total++;
    if (lat != lat_esperada(8'd13)) begin
      bad++;
      $display("FAIL t1_latency: got %0d want %0d", lat, lat_esperada(8'd13));
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL t1_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (resp_id !== e.id || resp_produto !== e.produto) begin
        bad++;
        $display("FAIL t1_result: got id=%b prod=%0d want id=%b prod=%0d", resp_id, resp_produto, e.id, e.produto);
      end
    end
    @(posedge clock);
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_release: got valid=%b busy=%b want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_ambos;
    int lat;
    esperado_t e;
    do_reset;
    req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd255;
    req1_valid = 1'b1; req1_a = 8'd2;   req1_b = 8'd3;
    resp_ready = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL t2_first_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      if (k == 0) sb.push_back('{id: 1'b0, produto: modelo(8'd255, 8'd255)});
      else        sb.push_back('{id: 1'b1, produto: modelo(8'd2, 8'd3)});
      esperar_resp(30, lat);
      total++;
      if (lat != lat_esperada(k == 0 ? 8'd255 : 8'd2)) begin
        bad++; $display("FAIL t2_latency%0d: got %0d want %0d", k, lat, lat_esperada(k == 0 ? 8'd255 : 8'd2));
      end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL t2_sb%0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (resp_id !== e.id || resp_produto !== e.produto) begin
          bad++;
          $display("FAIL t2_result%0d: got id=%b prod=%h want id=%b prod=%h", k, resp_id, resp_produto, e.id, e.produto);
        end
      end
      @(posedge clock);
      #1;
      total++;
      if ({req0_ready, req1_ready} !== (k == 0 ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL t2_next_grant%0d: got %b%b want %b", k, req0_ready, req1_ready, (k == 0 ? 2'b01 : 2'b10));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    esperado_t e;
    logic cap_id;
    logic [2*L-1:0] cap_p;
    do_reset;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd10;
    req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd3;
    resp_ready = 1'b0;
    @(posedge clock);
    sb.push_back('{id: 1'b0, produto: modelo(8'd9, 8'd10)});
    esperar_resp(30, lat);
    total++;
    if (lat != lat_esperada(8'd9)) begin
      bad++; $display("FAIL t3_latency: got %0d want %0d", lat, lat_esperada(8'd9));
    end
    cap_id = resp_id;
    cap_p  = resp_produto;
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL t3_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (cap_id !== e.id || cap_p !== e.produto) begin
        bad++; $display("FAIL t3_result: got id=%b prod=%0d want id=%b prod=%0d", cap_id, cap_p, e.id, e.produto);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_id !== cap_id || resp_produto !== cap_p ||
          busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL t3_hold%0d: got valid=%b id=%b prod=%0d busy=%b rdy=%b%b want 1 %b %0d 1 00",
                 c, resp_valid, resp_id, resp_produto, busy, req0_ready, req1_ready, cap_id, cap_p);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL t3_release: got valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_meio;
    int lat;
    int vistos;
    esperado_t e;
    do_reset;
    req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd100; resp_ready = 1'b1;
    @(posedge clock);
    sb.push_back('{id: 1'b0, produto: modelo(8'd200, 8'd100)});
    #1 req0_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    total++;
    if ({resp_valid, busy, resp_id, resp_produto, req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL t4_reset_outputs: got valid=%b busy=%b id=%b prod=%h want all 0",
               resp_valid, busy, resp_id, resp_produto);
    end
    @(negedge clock);
    reset = 1'b0;
    vistos = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (resp_valid !== 1'b0) vistos++;
    end
    total++;
    if (vistos != 0) begin
      bad++; $display("FAIL t4_no_resp: got %0d cycles with resp_valid want 0", vistos);
    end
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
    @(posedge clock);
    sb.push_back('{id: 1'b0, produto: modelo(8'd7, 8'd9)});
    #1 req0_valid = 1'b0;
    esperar_resp(30, lat);
    total++;
    if (lat != lat_esperada(8'd7)) begin
      bad++; $display("FAIL t4_latency: got %0d want %0d", lat, lat_esperada(8'd7));
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL t4_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (resp_id !== e.id || resp_produto !== e.produto) begin
        bad++; $display("FAIL t4_result: got id=%b prod=%0d want id=%b prod=%0d", resp_id, resp_produto, e.id, e.produto);
      end
    end
    @(posedge clock);
  endtask

  task automatic test_operandos_extremos;
    int lat;
    esperado_t e;
    logic [L-1:0] av;
    do_reset;
    resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      av = (k == 0) ? 8'd0 : 8'd1;
      @(negedge clock);
      req0_valid = 1'b1; req0_a = av; req0_b = 8'd77;
      @(posedge clock);
      sb.push_back('{id: 1'b0, produto: modelo(av, 8'd77)});
      #1 req0_valid = 1'b0;
      esperar_resp(30, lat);
      total++;
      if (lat != lat_esperada(av)) begin
        bad++; $display("FAIL t5_latency_a%0d: got %0d want %0d", av, lat, lat_esperada(av));
      end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL t5_sb_a%0d: scoreboard empty", av);
      end else begin
        e = sb.pop_front();
        if (resp_id !== e.id || resp_produto !== e.produto) begin
          bad++; $display("FAIL t5_result_a%0d: got prod=%0d want %0d", av, resp_produto, e.produto);
        end
      end
      @(posedge clock);
    end
  endtask

  task automatic test_operandos_mudam;
    int lat;
    esperado_t e;
    do_reset;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd6; req0_b = 8'd7;
    @(posedge clock);
    sb.push_back('{id: 1'b0, produto: modelo(8'd6, 8'd7)});
    #1;
    req0_a = 8'd15; req0_b = 8'd15;
    req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL t6_ready_busy: got %b%b want 00", req0_ready, req1_ready);
    end
    esperar_resp(30, lat);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (lat != lat_esperada(8'd6)) begin
      bad++; $display("FAIL t6_latency: got %0d want %0d", lat, lat_esperada(8'd6));
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL t6_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (resp_id !== e.id || resp_produto !== e.produto) begin
        bad++; $display("FAIL t6_result: got id=%b prod=%0d want id=%b prod=%0d", resp_id, resp_produto, e.id, e.produto);
      end
    end
    @(posedge clock);
  endtask

  initial begin
    test_reset;
    test_req0_only;
    test_ambos;
    test_backpressure;
    test_reset_meio;
    test_operandos_extremos;
    test_operandos_mudam;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
